// File: rtl/ram_stream_fifo.sv
// ============================================================================
// Module   : ram_stream_fifo
// Brief    : Valid/ready stream FIFO using an external dual-port RAM as
//            storage, with a 2-entry output buffer for full throughput.
//            Optional sticky error flags: define RAM_FIFO_ERR_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_stream_fifo #(
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  ram_wren_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    output logic                  ram_wren_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_b
`ifdef RAM_FIFO_ERR_FLAGS_EN
    ,
    output logic                  err_ovf,
    output logic                  err_unf
`endif
);

    localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic                  r_pending;
    logic [1:0]            r_buf_cnt;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;

    logic [ADDR_WIDTH:0]   w_ram_used;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic [1:0]            w_buf_after_pop;
    logic [2:0]            w_committed;
    logic [DATA_WIDTH-1:0] w_nb0;
    logic [DATA_WIDTH-1:0] w_nb1;

    assign w_ram_used = r_wr_ptr - r_rd_ptr;
    assign s_ready    = (w_ram_used != c_depth) && !rst;
    assign w_push     = s_valid && s_ready;
    assign m_valid    = (r_buf_cnt != 2'd0);
    assign m_data     = r_buf0;
    assign w_pop      = m_valid && m_ready;

    assign ram_wren_a = w_push;
    assign ram_addr_a = r_wr_ptr[ADDR_WIDTH-1:0];
    assign ram_din_a  = s_data;
    assign ram_wren_b = 1'b0;
    assign ram_addr_b = r_rd_ptr[ADDR_WIDTH-1:0];

    // Reserve a buffer slot for every word already in flight; a pop this
    // cycle frees one immediately so streaming runs at one word per cycle.
    assign w_buf_after_pop = r_buf_cnt - {1'b0, w_pop};
    assign w_committed     = {1'b0, w_buf_after_pop} + {2'b00, r_pending};
    assign w_issue         = (w_ram_used != '0) && (w_committed < 3'd2);

    assign count = {1'b0, w_ram_used}
                 + {{(ADDR_WIDTH+1){1'b0}}, r_pending}
                 + {{ADDR_WIDTH{1'b0}}, r_buf_cnt};

    always_comb begin
        w_nb0 = w_pop ? r_buf1 : r_buf0;
        w_nb1 = r_buf1;
        if (r_pending) begin
            if (w_buf_after_pop == 2'd0) begin
                w_nb0 = ram_dout_b;
            end else begin
                w_nb1 = ram_dout_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_pending <= 1'b0;
            r_buf_cnt <= 2'd0;
            r_buf0    <= '0;
            r_buf1    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_pending <= w_issue;
            r_buf_cnt <= w_buf_after_pop + {1'b0, r_pending};
            r_buf0    <= w_nb0;
            r_buf1    <= w_nb1;
        end
    end

`ifdef RAM_FIFO_ERR_FLAGS_EN
    logic r_err_ovf;
    logic r_err_unf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            if (s_valid && !s_ready) begin
                r_err_ovf <= 1'b1;
            end
            if (m_ready && !m_valid) begin
                r_err_unf <= 1'b1;
            end
        end
    end

    assign err_ovf = r_err_ovf;
    assign err_unf = r_err_unf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_stream_fifo.sv
// ============================================================================
// Module   : tb_ram_stream_fifo
// Brief    : Self-checking bench for ram_stream_fifo with a behavioural RAM
//            and a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_stream_fifo;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW+1:0] count;
    logic          ram_wren_a;
    logic [AW-1:0] ram_addr_a;
    logic [DW-1:0] ram_din_a;
    logic          ram_wren_b;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_dout_b;
`ifdef RAM_FIFO_ERR_FLAGS_EN
    logic          err_ovf;
    logic          err_unf;
`endif

    ram_stream_fifo #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .count      (count),
        .ram_wren_a (ram_wren_a),
        .ram_addr_a (ram_addr_a),
        .ram_din_a  (ram_din_a),
        .ram_wren_b (ram_wren_b),
        .ram_addr_b (ram_addr_b),
        .ram_dout_b (ram_dout_b)
`ifdef RAM_FIFO_ERR_FLAGS_EN
        ,
        .err_ovf    (err_ovf),
        .err_unf    (err_unf)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM: write on A, registered read on B
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wren_a) mem[ram_addr_a] <= ram_din_a;
        ram_dout_b <= mem[ram_addr_b];
    end

    int            n_vec  = 0;
    int            n_fail = 0;
    logic [DW-1:0] q[$];
    int            wr_idx = 0;
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;

    // Values seen at the most recent sampling point
    logic          sv_mv, sv_sr, sv_wren;
    logic [DW-1:0] sv_md;
    logic [AW-1:0] sv_addr;
    logic [AW+1:0] sv_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: sample at negedge, check against model, advance model.
    task automatic cycle();
        logic push, pop;
        @(negedge clk);
        sv_mv = m_valid; sv_md = m_data; sv_sr = s_ready;
        sv_wren = ram_wren_a; sv_addr = ram_addr_a; sv_cnt = count;
        chk("count", 32'(count), 32'(q.size()));
        chk("wren_b", 32'(ram_wren_b), 32'd0);
        if (q.size() < DEPTH) chk("s_ready_room", 32'(s_ready), 32'd1);
        if (q.size() == 0) chk("m_valid_empty", 32'(m_valid), 32'd0);
        if (m_valid && q.size() > 0) chk("m_data", 32'(m_data), 32'(q[0]));
        push = s_valid && s_ready;
        pop  = m_valid && m_ready;
        chk("wren_a", 32'(ram_wren_a), 32'(push));
        if (push) begin
            chk("addr_a", 32'(ram_addr_a), 32'(wr_idx % DEPTH));
            chk("din_a", 32'(ram_din_a), 32'(s_data));
        end
`ifdef RAM_FIFO_ERR_FLAGS_EN
        chk("err_ovf", 32'(err_ovf), 32'(exp_ovf));
        chk("err_unf", 32'(err_unf), 32'(exp_unf));
`endif
        if (s_valid && !s_ready) exp_ovf = 1'b1;
        if (m_ready && !m_valid) exp_unf = 1'b1;
        if (pop && q.size() > 0) void'(q.pop_front());
        if (push) begin
            q.push_back(s_data);
            wr_idx++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < max_cycles && q.size() > 0; i++) cycle();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_wren_a", 32'(ram_wren_a), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single push, latency of two edges to m_valid
        s_valid = 1'b1; s_data = 8'hA5;
        cycle();
        chk("lat_wren", 32'(sv_wren), 32'd1);
        chk("lat_addr", 32'(sv_addr), 32'd0);
        chk("lat_ready", 32'(sv_sr), 32'd1);
        s_valid = 1'b0;
        cycle(); chk("lat_mv_k", 32'(sv_mv), 32'd0);
        cycle(); chk("lat_mv_k1", 32'(sv_mv), 32'd0);
        cycle(); chk("lat_mv_k2", 32'(sv_mv), 32'd1);
        chk("lat_md", 32'(sv_md), 32'hA5);
        chk("lat_cnt", 32'(sv_cnt), 32'd1);
        drain(10);

        // Fill to capacity with the output stalled
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            s_valid = 1'b1; s_data = DW'(i);
            cycle();
            chk("fill_accept", 32'(sv_sr), 32'd1);
        end
        s_data = 8'h12;
        cycle();
        chk("full_ready", 32'(sv_sr), 32'd0);
        chk("full_count", 32'(sv_cnt), 32'(DEPTH + 2));
        s_valid = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            cycle();
            chk("drain_gap", 32'(sv_mv), 32'd1);
            chk("drain_seq", 32'(sv_md), 32'(i));
        end
        drain(5);

        // Continuous streaming
        m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_valid = 1'b1; s_data = DW'(8'h40 + i);
            cycle();
            if (i >= 3) chk("stream_gap", 32'(sv_mv), 32'd1);
            chk("stream_cnt_le3", 32'(sv_cnt <= 3), 32'd1);
        end
        drain(10);

        // Toggling m_ready while pushing
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1; s_data = DW'(8'h10 + i);
            m_ready = ~i[0];
            cycle();
        end
        s_valid = 1'b0;
        for (int i = 0; i < 60 && q.size() > 0; i++) begin
            m_ready = ~i[0];
            cycle();
        end
        chk("toggle_empty", 32'(q.size()), 32'd0);

        // Mid-stream reset
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = DW'(8'hC0 + i);
            cycle();
        end
        s_valid = 1'b0;
        cycle(); cycle();
        chk("pre_rst_cnt", 32'(sv_cnt), 32'd10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete(); wr_idx = 0; exp_ovf = 1'b0; exp_unf = 1'b0;
        s_valid = 1'b1; s_data = 8'h3C;
        cycle();
        chk("post_rst_cnt", 32'(sv_cnt), 32'd0);
        chk("post_rst_mv", 32'(sv_mv), 32'd0);
        chk("post_rst_sr", 32'(sv_sr), 32'd1);
        s_valid = 1'b0;
        cycle(); cycle();
        cycle();
        chk("post_rst_md", 32'(sv_md), 32'h3C);
        drain(5);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            s_valid = 1'($urandom);
            s_data  = DW'($urandom);
            m_ready = ($urandom_range(0, 3) != 0) ? i[6] | 1'($urandom) : 1'b0;
            cycle();
        end
        drain(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
